// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module  : led_pkg
// Brief   : Mode encoding shared by the LED blink controller and its users.
// Rev     : 1.0
// ============================================================================
package led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PULSE = 2'd3
    } mode_t;

endpackage
`default_nettype wire

// File: rtl/led_blink_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : led_blink_ctrl_if
// Brief   : Configuration write port and LED status outputs of led_blink_ctrl.
// Rev     : 1.0
// ============================================================================
interface led_blink_ctrl_if #(
    parameter int N_CH  = 4,
    parameter int PER_W = 12,
    parameter int CNT_W = 8
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic             cfg_wr;
    logic [CH_W-1:0]  cfg_ch;
    logic [1:0]       cfg_mode;
    logic [PER_W-1:0] cfg_period;
    logic [CNT_W-1:0] cfg_count;
    logic [N_CH-1:0]  led;
    logic [N_CH-1:0]  busy;
    logic [N_CH-1:0]  done;
    logic             cfg_err;

    modport master (
        output cfg_wr, cfg_ch, cfg_mode, cfg_period, cfg_count,
        input  led, busy, done, cfg_err
    );

    modport slave (
        input  cfg_wr, cfg_ch, cfg_mode, cfg_period, cfg_count,
        output led, busy, done, cfg_err
    );
endinterface
`default_nettype wire

// File: rtl/led_blink_ctrl_tick_gen.sv
`default_nettype none
// ============================================================================
// Module  : tick_gen
// Brief   : Free-running prescaler, one-cycle tick every CLK_DIV clocks.
// Rev     : 1.0
// ============================================================================
module tick_gen #(
    parameter int CLK_DIV = 50_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int              DIV_W  = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] C_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;

    always_comb begin
        div_cnt_d = (div_cnt_q == C_LAST) ? '0 : div_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    assign tick = (div_cnt_q == C_LAST);
endmodule
`default_nettype wire

// File: rtl/led_blink_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : led_blink_ctrl
// Brief   : N-channel LED driver (OFF/ON/BLINK/PULSE) on a shared base tick.
// Rev     : 1.0
// ============================================================================
module led_blink_ctrl
    import led_pkg::*;
#(
    parameter int CLK_DIV    = 50_000,
    parameter int N_CH       = 4,
    parameter int PER_W      = 12,
    parameter int CNT_W      = 8,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    led_blink_ctrl_if.slave   bus
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic  w_tick;
    logic  w_bad_ch;
    logic  err_q;
    mode_t w_cfg_mode;

    tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick)
    );

    assign w_cfg_mode = mode_t'(bus.cfg_mode);

    // Only a non-power-of-two channel count leaves unused index codes.
    if (N_CH < (1 << CH_W)) begin : g_range_chk
        assign w_bad_ch = (int'(bus.cfg_ch) >= N_CH);
    end else begin : g_no_range_chk
        assign w_bad_ch = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= bus.cfg_wr && w_bad_ch;
        end
    end

    assign bus.cfg_err = err_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic             w_hit;
        mode_t            mode_q,  mode_d;
        logic             lit_q,   lit_d;
        logic [PER_W-1:0] per_q,   per_d;
        logic [PER_W-1:0] ph_q,    ph_d;
        logic [CNT_W-1:0] left_q,  left_d;
        logic             done_q,  done_d;
        logic             led_q;
        logic             busy_q;

        assign w_hit = bus.cfg_wr && (bus.cfg_ch == CH_W'(i));

        always_comb begin
            mode_d = mode_q;
            lit_d  = lit_q;
            per_d  = per_q;
            ph_d   = ph_q;
            left_d = left_q;
            done_d = 1'b0;
            if (w_hit) begin
                // A write overrides any tick on the same edge and aborts a burst silently.
                mode_d = w_cfg_mode;
                per_d  = bus.cfg_period;
                ph_d   = '0;
                left_d = bus.cfg_count;
                lit_d  = (w_cfg_mode != MODE_OFF);
                if (w_cfg_mode == MODE_PULSE && bus.cfg_count == '0) begin
                    mode_d = MODE_OFF;
                    lit_d  = 1'b0;
                    done_d = 1'b1;
                end
            end else if (w_tick && (mode_q == MODE_BLINK || mode_q == MODE_PULSE)) begin
                if (ph_q == per_q) begin
                    ph_d  = '0;
                    lit_d = ~lit_q;
                    if (mode_q == MODE_PULSE && lit_q) begin
                        left_d = left_q - 1'b1;
                        if (left_q == CNT_W'(1)) begin
                            mode_d = MODE_OFF;
                            done_d = 1'b1;
                        end
                    end
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mode_q <= MODE_OFF;
                lit_q  <= 1'b0;
                per_q  <= '0;
                ph_q   <= '0;
                left_q <= '0;
                done_q <= 1'b0;
                led_q  <= ACTIVE_LOW;
                busy_q <= 1'b0;
            end else begin
                mode_q <= mode_d;
                lit_q  <= lit_d;
                per_q  <= per_d;
                ph_q   <= ph_d;
                left_q <= left_d;
                done_q <= done_d;
                led_q  <= lit_d ^ ACTIVE_LOW;
                busy_q <= (mode_d != MODE_OFF);
            end
        end

        assign bus.led[i]  = led_q;
        assign bus.busy[i] = busy_q;
        assign bus.done[i] = done_q;
    end
endmodule
`default_nettype wire

// File: tb/tb_led_blink_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_led_blink_ctrl
// Brief   : Randomized self-checking bench against a tick-count reference model.
// Rev     : 1.0
// ============================================================================
module tb_led_blink_ctrl;
    localparam int CLK_DIV = 4;

    logic clk;
    logic rst_n;

    led_blink_ctrl_if #(.N_CH(4), .PER_W(12), .CNT_W(8)) bus4 ();
    led_blink_ctrl_if #(.N_CH(3), .PER_W(12), .CNT_W(8)) bus3 ();

    led_blink_ctrl #(.CLK_DIV(CLK_DIV), .N_CH(4), .PER_W(12), .CNT_W(8), .ACTIVE_LOW(1'b1)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    led_blink_ctrl #(.CLK_DIV(CLK_DIV), .N_CH(3), .PER_W(12), .CNT_W(8), .ACTIVE_LOW(1'b1)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge-time %0t)", tag, got, exp, $time);
    endtask

    // Reference model: each channel remembers its last write; its state is a
    // function of how many base ticks have elapsed since that write.
    int e;
    int m_mode [4];
    int m_per  [4];
    int m_cnt  [4];
    int m_w    [4];

    function automatic void model_reset();
        for (int c = 0; c < 4; c++) begin
            m_mode[c] = 0; m_per[c] = 0; m_cnt[c] = 0; m_w[c] = 0;
        end
        e = 0;
    endfunction

    function automatic void model_eval(input int c, output bit lit, output bit busy, output bit done);
        int n, len, k, last;
        n    = e / CLK_DIV - m_w[c] / CLK_DIV;
        len  = m_per[c] + 1;
        k    = n / len;
        lit  = 1'b0; busy = 1'b0; done = 1'b0;
        case (m_mode[c])
            1: begin lit = 1'b1; busy = 1'b1; end
            2: begin lit = (k % 2 == 0); busy = 1'b1; end
            3: begin
                if (m_cnt[c] == 0) begin
                    done = (e == m_w[c]);
                end else begin
                    last = (2 * m_cnt[c] - 1) * len;
                    if (n >= last) begin
                        done = (n == last) && (e % CLK_DIV == 0) && (e > m_w[c]);
                    end else begin
                        lit  = (k % 2 == 0);
                        busy = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    endfunction

    task automatic check_outputs();
        logic [3:0] x_led, x_busy, x_done;
        bit l, b, d;
        for (int c = 0; c < 4; c++) begin
            model_eval(c, l, b, d);
            x_led[c] = ~l; x_busy[c] = b; x_done[c] = d;
        end
        check("led",     32'(bus4.led),     32'(x_led));
        check("busy",    32'(bus4.busy),    32'(x_busy));
        check("done",    32'(bus4.done),    32'(x_done));
        check("cfg_err", 32'(bus4.cfg_err), 32'd0);
        check("tick",    32'(dut4.u_tick.tick), 32'((e + 1) % CLK_DIV == 0));
    endtask

    task automatic step(input bit wr, input int ch, input int mode, input int per, input int cnt);
        bus4.cfg_wr     = wr;
        bus4.cfg_ch     = 2'(ch);
        bus4.cfg_mode   = 2'(mode);
        bus4.cfg_period = 12'(per);
        bus4.cfg_count  = 8'(cnt);
        @(posedge clk);
        e++;
        if (wr) begin
            m_mode[ch] = mode; m_per[ch] = per; m_cnt[ch] = cnt; m_w[ch] = e;
        end
        #1;
        bus4.cfg_wr = 1'b0;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 0);
    endtask

    task automatic align_tick();
        while ((e + 1) % CLK_DIV != 0) step(1'b0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus4.cfg_wr = 1'b0; bus4.cfg_ch = '0; bus4.cfg_mode = '0; bus4.cfg_period = '0; bus4.cfg_count = '0;
        bus3.cfg_wr = 1'b0; bus3.cfg_ch = '0; bus3.cfg_mode = '0; bus3.cfg_period = '0; bus3.cfg_count = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_outputs();

        idle(100);

        step(1'b1, 1, 2, 2, 0);
        idle(60);

        step(1'b1, 2, 3, 0, 3);
        idle(40);

        step(1'b1, 0, 3, 0, 0);
        idle(4);

        align_tick();
        step(1'b1, 3, 2, 1, 0);
        idle(9);
        align_tick();
        step(1'b1, 3, 1, 0, 0);
        idle(20);

        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(15) == 0)
                step(1'b1, int'($urandom_range(3)), int'($urandom_range(3)),
                     int'($urandom_range(3)), int'($urandom_range(3)));
            else
                step(1'b0, 0, 0, 0, 0);
        end

        // Out-of-range channel on the 3-channel instance
        bus3.cfg_wr = 1'b1; bus3.cfg_ch = 2'd0; bus3.cfg_mode = 2'd1;
        step(1'b0, 0, 0, 0, 0);
        bus3.cfg_wr = 1'b0;
        check("n3_led_on",  32'(bus3.led),  32'h6);
        check("n3_busy_on", 32'(bus3.busy), 32'h1);
        check("n3_err_ok",  32'(bus3.cfg_err), 32'd0);
        bus3.cfg_wr = 1'b1; bus3.cfg_ch = 2'd3; bus3.cfg_mode = 2'd0;
        step(1'b0, 0, 0, 0, 0);
        bus3.cfg_wr = 1'b0;
        check("n3_err",      32'(bus3.cfg_err), 32'd1);
        check("n3_led_keep", 32'(bus3.led),     32'h6);
        check("n3_busy_keep",32'(bus3.busy),    32'h1);
        step(1'b0, 0, 0, 0, 0);
        check("n3_err_pulse", 32'(bus3.cfg_err), 32'd0);

        // Asynchronous reset in the middle of a burst
        step(1'b1, 2, 3, 1, 3);
        idle(7);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_led",   32'(bus4.led),  32'hF);
        check("rst_busy",  32'(bus4.busy), 32'h0);
        check("rst_done",  32'(bus4.done), 32'h0);
        check("rst_led3",  32'(bus3.led),  32'h7);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check_outputs();
        idle(40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
